gpio_stream_packer: RTL and testbench

Width-adapting val/rdy packer that sits directly upstream of input port 1 of the 32-bit module-input crossbar. It replaces the zero-extension of the 8-bit GPIO input bus. It collects consecutive 8-bit GPIO beats into one 32-bit word, so the accelerators behind the crossbar receive full operands from the pins. A flush request emits a partially filled word, zero-padded. A holding register decouples assembly from downstream backpressure.

---
 rtl/gpio_stream_packer_if.sv | 23 ++
 rtl/gpio_stream_packer.sv | 62 ++++++
 tb/tb_gpio_stream_packer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_stream_packer_if.sv
// gpio_stream_packer_if: beat-in / word-out val/rdy bundle with flush and beat count.
interface gpio_stream_packer_if #(
   parameter int IN_WIDTH  = 8,
   parameter int OUT_WIDTH = 32
);
   localparam int BW = $clog2(OUT_WIDTH / IN_WIDTH) + 1;
   logic                 i_stream_val;
   logic [IN_WIDTH-1:0]  i_stream_data;
   logic                 i_stream_rdy;
   logic                 flush;
   logic                 o_stream_val;
   logic [OUT_WIDTH-1:0] o_stream_data;
   logic                 o_stream_rdy;
   logic [BW-1:0]        o_stream_beats;
   modport master (
      output i_stream_val, i_stream_data, flush, o_stream_rdy,
      input  i_stream_rdy, o_stream_val, o_stream_data, o_stream_beats
   );
   modport slave (
      input  i_stream_val, i_stream_data, flush, o_stream_rdy,
      output i_stream_rdy, o_stream_val, o_stream_data, o_stream_beats
   );
endinterface

// File: rtl/gpio_stream_packer.sv
// gpio_stream_packer: packs IN_WIDTH GPIO beats LSB-first into OUT_WIDTH words, with zero-padded flush.
module gpio_stream_packer #(
   parameter int IN_WIDTH  = 8,
   parameter int OUT_WIDTH = 32
) (
   input logic                clk,
   input logic                reset,
   gpio_stream_packer_if.slave s
);
   localparam int BEATS = OUT_WIDTH / IN_WIDTH;
   localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;
   localparam int BW    = $clog2(BEATS) + 1;
   logic [OUT_WIDTH-1:0] asm_q, ins, out_data;
   logic [CW-1:0]        cnt;
   logic [BW-1:0]        out_beats;
   logic                 out_val, flush_pending;
   logic                 acc, last, out_fire, drain;
   assign last     = cnt == CW'(BEATS - 1);
   assign out_fire = out_val && s.o_stream_rdy;
   // Ready depends only on registers so the crossbar's ready never loops back into the pins.
   assign s.i_stream_rdy   = !reset && !flush_pending && !(out_val && last);
   assign acc              = s.i_stream_val && s.i_stream_rdy;
   assign drain            = flush_pending && cnt != '0 && (!out_val || out_fire);
   assign s.o_stream_val   = out_val;
   assign s.o_stream_data  = out_data;
   assign s.o_stream_beats = out_beats;
   always_comb begin
      ins = asm_q;
      ins[cnt*IN_WIDTH +: IN_WIDTH] = s.i_stream_data;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         asm_q         <= '0;
         cnt           <= '0;
         out_data      <= '0;
         out_beats     <= '0;
         out_val       <= 1'b0;
         flush_pending <= 1'b0;
      end else begin
         if (out_fire) out_val <= 1'b0;
         // A reload below overrides the clear above in the same cycle.
         if (acc && last) begin
            out_data  <= ins;
            out_beats <= BW'(BEATS);
            out_val   <= 1'b1;
            cnt       <= '0;
            asm_q     <= '0;
         end else if (acc) begin
            asm_q <= ins;
            cnt   <= cnt + CW'(1);
         end else if (drain) begin
            out_data  <= asm_q;
            out_beats <= BW'(cnt);
            out_val   <= 1'b1;
            cnt       <= '0;
            asm_q     <= '0;
         end
         if (flush_pending && (cnt == '0 || drain)) flush_pending <= 1'b0;
         else if (s.flush) flush_pending <= 1'b1;
      end
   end
endmodule

// File: tb/tb_gpio_stream_packer.sv
// tb_gpio_stream_packer: directed scenarios plus randomized traffic against a beat-list word model.
module tb_gpio_stream_packer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int total = 0;
   int bad = 0;
   int n_words = 0;
   int cyc = 0;
   logic [7:0]  cur[$];
   logic [34:0] exp_q[$];
   logic [34:0] got_q[$];
   logic        held_flag = 1'b0;
   logic [34:0] held_word;
   gpio_stream_packer_if bus ();
   gpio_stream_packer dut (.clk(clk), .reset(reset), .s(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic close_word();
      logic [31:0] w = '0;
      for (int i = 0; i < cur.size(); i++) w[i*8 +: 8] = cur[i];
      exp_q.push_back({3'(cur.size()), w});
      cur.delete();
   endtask
   // Model: every accepted beat joins the open word; 4 beats or a flush closes it.
   always @(negedge clk) begin
      logic [34:0] obs, e;
      obs = {bus.o_stream_beats, bus.o_stream_data};
      if (reset) begin
         cur.delete();
         exp_q.delete();
      end else begin
         if (held_flag) begin
            total++;
            if (!bus.o_stream_val || obs !== held_word) begin
               bad++;
               $display("FAIL hold_stable val=%0b word=%h required val=1 word=%h", bus.o_stream_val, obs, held_word);
            end
         end
         if (bus.o_stream_val && bus.o_stream_rdy) begin
            total++;
            n_words++;
            got_q.push_back(obs);
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL out_word got=%h required none", obs);
            end else begin
               e = exp_q.pop_front();
               if (obs !== e) begin
                  bad++;
                  $display("FAIL out_word got=%h required=%h", obs, e);
               end
            end
         end
         if (bus.i_stream_val && bus.i_stream_rdy) begin
            cur.push_back(bus.i_stream_data);
            if (cur.size() == 4) close_word();
         end
         if (bus.flush && cur.size() != 0) close_word();
      end
      held_flag = !reset && bus.o_stream_val && !bus.o_stream_rdy;
      held_word = obs;
   end
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [7:0] b);
      logic ok = 1'b0;
      bus.i_stream_val = 1'b1;
      bus.i_stream_data = b;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (bus.i_stream_rdy) ok = 1'b1;
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL send_timeout beat=%h not accepted within 200 cycles", b);
      end
      @(posedge clk);
      #1;
      bus.i_stream_val = 1'b0;
   endtask
   task automatic pulse_reset();
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
   endtask
   task automatic test_reset();
      reset = 1'b1;
      tick(3);
      @(negedge clk);
      total++;
      if (bus.o_stream_val !== 1'b0 || bus.o_stream_data !== 32'h0 || bus.o_stream_beats !== 3'd0 || bus.i_stream_rdy !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs val=%b data=%h beats=%0d rdy=%b required 0/0/0/0", bus.o_stream_val, bus.o_stream_data, bus.o_stream_beats, bus.i_stream_rdy);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      total++;
      if (bus.i_stream_rdy !== 1'b1) begin
         bad++;
         $display("FAIL reset_rdy_after got=%b required=1", bus.i_stream_rdy);
      end
      tick(1);
   endtask
   task automatic test_full_word();
      int w0 = n_words;
      int t0 = cyc;
      bus.o_stream_rdy = 1'b1;
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      total++;
      if (cyc - t0 != 4) begin
         bad++;
         $display("FAIL full_b2b cycles=%0d required=4", cyc - t0);
      end
      @(negedge clk);
      total++;
      if (bus.o_stream_val !== 1'b1 || bus.o_stream_data !== 32'h44332211 || bus.o_stream_beats !== 3'd4) begin
         bad++;
         $display("FAIL full_latency val=%b data=%h beats=%0d required 1/44332211/4", bus.o_stream_val, bus.o_stream_data, bus.o_stream_beats);
      end
      @(negedge clk);
      total++;
      if (bus.o_stream_val !== 1'b0) begin
         bad++;
         $display("FAIL full_one_cycle val=%b required=0", bus.o_stream_val);
      end
      tick(2);
      total++;
      if (n_words - w0 != 1) begin
         bad++;
         $display("FAIL full_count words=%0d required=1", n_words - w0);
      end
   endtask
   task automatic test_back_to_back();
      int w0 = n_words;
      bus.o_stream_rdy = 1'b0;
      for (int i = 1; i <= 7; i++) send(8'(i * 8'h11));
      bus.i_stream_val = 1'b1;
      bus.i_stream_data = 8'h88;
      tick(3);
      @(negedge clk);
      total++;
      if (bus.i_stream_rdy !== 1'b0 || bus.o_stream_val !== 1'b1 || bus.o_stream_data !== 32'h44332211) begin
         bad++;
         $display("FAIL bp_stall rdy=%b val=%b data=%h required 0/1/44332211", bus.i_stream_rdy, bus.o_stream_val, bus.o_stream_data);
      end
      @(posedge clk);
      #1;
      bus.o_stream_rdy = 1'b1;
      send(8'h88);
      tick(3);
      total++;
      if (n_words - w0 != 2 || got_q[got_q.size()-2] !== {3'd4, 32'h44332211} || got_q[got_q.size()-1] !== {3'd4, 32'h88776655}) begin
         bad++;
         $display("FAIL bp_order words=%0d last=%h required 2 words ending 488776655", n_words - w0, got_q[got_q.size()-1]);
      end
   endtask
   task automatic test_flush_partial();
      bus.o_stream_rdy = 1'b1;
      send(8'hAA); send(8'hBB);
      bus.flush = 1'b1;
      tick(1);
      bus.flush = 1'b0;
      @(negedge clk);
      total++;
      if (bus.i_stream_rdy !== 1'b0) begin
         bad++;
         $display("FAIL flush_rdy_low got=%b required=0", bus.i_stream_rdy);
      end
      @(negedge clk);
      total++;
      if (bus.o_stream_val !== 1'b1 || bus.o_stream_data !== 32'h0000BBAA || bus.o_stream_beats !== 3'd2) begin
         bad++;
         $display("FAIL flush_partial val=%b data=%h beats=%0d required 1/0000bbaa/2", bus.o_stream_val, bus.o_stream_data, bus.o_stream_beats);
      end
      tick(1);
      send(8'hCC); send(8'hDD); send(8'hEE); send(8'hFF);
      tick(2);
      total++;
      if (got_q[got_q.size()-1] !== {3'd4, 32'hFFEEDDCC}) begin
         bad++;
         $display("FAIL flush_fresh got=%h required=4ffeeddcc", got_q[got_q.size()-1]);
      end
   endtask
   task automatic test_flush_edge();
      int w0 = n_words;
      bus.o_stream_rdy = 1'b1;
      bus.flush = 1'b1;
      tick(1);
      bus.flush = 1'b0;
      tick(4);
      total++;
      if (n_words != w0) begin
         bad++;
         $display("FAIL flush_empty words=%0d required=0", n_words - w0);
      end
      send(8'hD1); send(8'hD2); send(8'hD3);
      bus.flush = 1'b1;
      send(8'hD4);
      bus.flush = 1'b0;
      tick(5);
      total++;
      if (n_words - w0 != 1 || got_q[got_q.size()-1] !== {3'd4, 32'hD4D3D2D1}) begin
         bad++;
         $display("FAIL flush_with_last words=%0d last=%h required 1 word 4d4d3d2d1", n_words - w0, got_q[got_q.size()-1]);
      end
   endtask
   task automatic test_flush_held();
      int w0 = n_words;
      bus.o_stream_rdy = 1'b0;
      send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h5A);
      bus.flush = 1'b1;
      tick(1);
      bus.flush = 1'b0;
      tick(5);
      @(negedge clk);
      total++;
      if (bus.o_stream_val !== 1'b1 || bus.o_stream_data !== 32'h04030201 || n_words != w0) begin
         bad++;
         $display("FAIL flush_held_wait val=%b data=%h words=%0d required 1/04030201/0", bus.o_stream_val, bus.o_stream_data, n_words - w0);
      end
      @(posedge clk);
      #1;
      bus.o_stream_rdy = 1'b1;
      tick(6);
      total++;
      if (n_words - w0 != 2 || got_q[got_q.size()-1] !== {3'd1, 32'h0000005A}) begin
         bad++;
         $display("FAIL flush_held_emit words=%0d last=%h required 2 words ending 10000005a", n_words - w0, got_q[got_q.size()-1]);
      end
   endtask
   task automatic test_reset_mid();
      int w0 = n_words;
      bus.o_stream_rdy = 1'b1;
      send(8'h01); send(8'h02);
      pulse_reset();
      bus.o_stream_rdy = 1'b0;
      send(8'h09); send(8'h08); send(8'h07); send(8'h06);
      pulse_reset();
      @(negedge clk);
      total++;
      if (bus.o_stream_val !== 1'b0 || n_words != w0) begin
         bad++;
         $display("FAIL reset_held val=%b words=%0d required 0/0", bus.o_stream_val, n_words - w0);
      end
      @(posedge clk);
      #1;
      bus.o_stream_rdy = 1'b1;
      send(8'h10); send(8'h20); send(8'h30); send(8'h40);
      tick(3);
      total++;
      if (n_words - w0 != 1 || got_q[got_q.size()-1] !== {3'd4, 32'h40302010}) begin
         bad++;
         $display("FAIL reset_fresh words=%0d last=%h required 1 word 440302010", n_words - w0, got_q[got_q.size()-1]);
      end
   endtask
   task automatic test_random();
      for (int i = 0; i < 2000; i++) begin
         bus.i_stream_val  = $urandom_range(0, 9) < 7;
         bus.i_stream_data = 8'($urandom);
         bus.flush         = $urandom_range(0, 19) == 0;
         bus.o_stream_rdy  = $urandom_range(0, 9) < 6;
         tick(1);
      end
      bus.i_stream_val = 1'b0;
      bus.flush = 1'b0;
      bus.o_stream_rdy = 1'b1;
      tick(2);
      bus.flush = 1'b1;
      tick(1);
      bus.flush = 1'b0;
      tick(20);
      total++;
      if (exp_q.size() != 0 || cur.size() != 0) begin
         bad++;
         $display("FAIL random_drain pending_words=%0d open_beats=%0d required 0/0", exp_q.size(), cur.size());
      end
   endtask
   initial begin
      bus.i_stream_val = 1'b0;
      bus.i_stream_data = '0;
      bus.flush = 1'b0;
      bus.o_stream_rdy = 1'b0;
      test_reset();
      test_full_word();
      test_back_to_back();
      test_flush_partial();
      test_flush_edge();
      test_flush_held();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end
endmodule
